acc_arbiter: RTL and testbench
==============================

Name: acc_arbiter

Overview:
Round-robin controller that shares one 16-bit accumulator datapath among NREQ requesters.
- Grants the accumulator to one requester per burst and clears it at burst start.
- Sums up to BURST_LEN valid samples from the granted requester.
- Presents the result with a valid/ack handshake.
- Sits between several sample producers and a single result consumer.

Parameters:
NREQ, 4, number of requesters (2..8)
BURST_LEN, 8, maximum samples accumulated per grant (1..256)
IDW, 2, width of QID, ceil(log2(NREQ)) (minimum 1)

Ports:
CLK  in  1  rising-edge clock
RST  in  1  reset, synchronous, active-high
REQ  in  NREQ  per-requester request, level; held while the requester wants the accumulator
DV  in  NREQ  per-requester sample valid
D  in  16*NREQ  packed samples; requester i uses bits [16*i+15:16*i]
GNT  out  NREQ  one-hot grant, registered
Q  out  16  accumulator value
QV  out  1  result valid
QACK  in  1  consumer accepts result
QID  out  IDW  index of the requester that owns Q
BUSY  out  1  high in any state other than IDLE

Behaviour:
- One clock; reset is synchronous and active-high, on CLK rising edge.
- RST has priority over everything:
  - State returns to IDLE.
  - GNT, Q, QV, QID, BUSY and the sample counter all go to 0.
  - Last-grant pointer goes to NREQ-1, so requester 0 wins first.
  - RST mid-burst or mid-handshake discards the partial result with no further output.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - If REQ is nonzero, select the first set bit searching upward from pointer+1, wrapping modulo NREQ.
  - Next cycle: GNT = onehot(sel), QID = sel, Q = 0, count = 0, pointer = sel, BUSY = 1, state = ACCUM.
  - If REQ is zero, stay in IDLE with all outputs held.
- ACCUM, granted index g:
  - Each cycle with DV[g]=1: Q <= Q + D[g] modulo 2^16, count <= count+1.
  - If this is the BURST_LEN-th sample (count == BURST_LEN-1 with DV[g]), go to DONE.
  - DV of non-granted requesters is ignored.
  - If REQ[g]=0 and DV[g]=0, go to DONE early with the partial sum. Zero samples gives Q=0.
  - If REQ[g]=0 and DV[g]=1 in the same cycle, the sample is still accumulated, then go to DONE.
- DONE:
  - GNT = 0 on entry; QV = 1; Q and QID are held stable.
  - When QACK=1 and QV=1: QV <= 0, BUSY <= 0, state = IDLE.
  - QACK outside DONE is ignored.
- Latency:
  - First sample can be accumulated one cycle after REQ is seen in IDLE.
  - QV rises one cycle after the final accepted sample.
  - Earliest new grant is 2 cycles after the QACK cycle, because IDLE spends one cycle arbitrating.
- Fairness: a requester holding REQ continuously is granted at least once every NREQ bursts.
- New REQ bits arriving during ACCUM or DONE wait for the next IDLE arbitration.

Optional Feature:
SAT_EN
- Defined:
  - Addition saturates at 16'hFFFF instead of wrapping.
  - An extra output OVF (1 bit) is added.
  - OVF is set when any add saturates in the current burst, held through DONE, and cleared at the next grant and on RST.
- Undefined:
  - Addition wraps modulo 2^16.
  - No OVF port exists.

Test Plan:
- Reset → idle outputs: RST=1 for 2 cycles with REQ=4'b1111 → GNT=0, Q=0, QV=0, BUSY=0. After release, first GNT=4'b0001, QID=0.
- Full burst:
  - Stimulus: REQ[2]=1, DV[2]=1 for 8 cycles with D[2]=1..8.
  - Response: Q=36, QID=2, QV=1 one cycle after the 8th sample. QACK → QV=0, BUSY=0 next cycle.
- Round-robin and DV isolation:
  - Stimulus: REQ=4'b1011 held; each burst ACKed; DV held high on all requesters.
  - Response: grant order 0,1,3,0. DV[1] high during requester 0's burst does not change Q.
- Early release:
  - Stimulus: REQ[1] drops after 3 samples of 16'h0100, with DV[1]=1 in the drop cycle on a 4th sample of 16'h0100.
  - Response: Q=16'h0400, QV=1.
- Wrap / saturation:
  - Stimulus: samples 16'hFFF0, then 16'h0020.
  - Response without SAT_EN: Q=16'h0010. With SAT_EN: Q=16'hFFFF, OVF=1.
- Reset mid-operation:
  - Stimulus: RST during ACCUM after 5 samples, and separately during DONE with QACK=0.
  - Response: state IDLE, QV=0, Q=0 next cycle; pointer reset, so requester 0 is granted first afterwards.

Source files
------------

// File: rtl/acc_arbiter.sv
// ============================================================================
// Module : acc_arbiter
// Brief  : Round-robin arbiter sharing one 16-bit accumulator among NREQ
//          requesters; result returned over a QV/QACK handshake.
//          Optional macro SAT_EN: saturating add plus OVF output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module acc_arbiter #(
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 8,
    parameter int IDW       = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ-1:0]      DV,
    input  logic [16*NREQ-1:0]   D,
    output logic [NREQ-1:0]      GNT,
    output logic [15:0]          Q,
    output logic                 QV,
    input  logic                 QACK,
    output logic [IDW-1:0]       QID,
    output logic                 BUSY
`ifdef SAT_EN
    ,
    output logic                 OVF
`endif
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      state, next_state;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IDW-1:0]  ptr, ptr_n, sel, idx_c;
    logic [NREQ-1:0] gnt_n;
    logic [15:0]     q_n, d_g, add_res;
    logic [IDW-1:0]  qid_n;
    logic            qv_n, busy_n, found;
    logic            dv_g, req_g, last_sample, end_burst;
    logic            sat_hit;
    logic            ovf_r, ovf_n;
    logic [15:0]     lanes [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lanes[i] = D[16*i +: 16];
    end

    assign d_g   = lanes[QID];
    assign dv_g  = DV[QID];
    assign req_g = REQ[QID];

    // Search upward from the last winner so a held request waits at most NREQ-1 bursts
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx_c = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_c = IDW'((int'(ptr) + k) % NREQ);
            if (!found && REQ[idx_c]) begin
                found = 1'b1;
                sel   = idx_c;
            end
        end
    end

`ifdef SAT_EN
    logic [16:0] sum;
    always_comb begin
        sum     = {1'b0, Q} + {1'b0, d_g};
        sat_hit = sum[16];
        add_res = sum[16] ? 16'hFFFF : sum[15:0];
    end
    assign OVF = ovf_r;
`else
    always_comb begin
        add_res = Q + d_g;
        sat_hit = 1'b0;
    end
`endif

    assign last_sample = dv_g && (cnt == LAST);
    assign end_burst   = last_sample || !req_g;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|REQ)       next_state = ACCUM;
            ACCUM:   if (end_burst)  next_state = DONE;
            DONE:    if (QACK && QV) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gnt_n  = GNT;
        q_n    = Q;
        qv_n   = QV;
        qid_n  = QID;
        busy_n = BUSY;
        cnt_n  = cnt;
        ptr_n  = ptr;
        ovf_n  = ovf_r;
        case (state)
            IDLE: if (|REQ) begin
                gnt_n  = NREQ'(1) << sel;
                qid_n  = sel;
                q_n    = '0;
                cnt_n  = '0;
                ptr_n  = sel;
                busy_n = 1'b1;
                ovf_n  = 1'b0;
            end
            ACCUM: begin
                if (dv_g) begin
                    q_n   = add_res;
                    cnt_n = cnt + 1'b1;
                    if (sat_hit) ovf_n = 1'b1;
                end
                if (end_burst) begin
                    gnt_n = '0;
                    qv_n  = 1'b1;
                end
            end
            DONE: if (QACK && QV) begin
                qv_n   = 1'b0;
                busy_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            GNT   <= '0;
            Q     <= '0;
            QV    <= 1'b0;
            QID   <= '0;
            BUSY  <= 1'b0;
            cnt   <= '0;
            ptr   <= IDW'(NREQ - 1);
            ovf_r <= 1'b0;
        end else begin
            GNT   <= gnt_n;
            Q     <= q_n;
            QV    <= qv_n;
            QID   <= qid_n;
            BUSY  <= busy_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            ovf_r <= ovf_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_acc_arbiter.sv
// ============================================================================
// Module : tb_acc_arbiter
// Brief  : Scoreboard bench for acc_arbiter; burst-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_acc_arbiter;

    localparam int NREQ      = 4;
    localparam int BURST_LEN = 8;
    localparam int IDW       = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ-1:0]     dv  = '0;
    logic [16*NREQ-1:0]  d   = '0;
    logic                qack = 1'b0;
    logic [NREQ-1:0]     gnt;
    logic [15:0]         q;
    logic                qv;
    logic [IDW-1:0]      qid;
    logic                busy;
`ifdef SAT_EN
    logic                ovf;
`endif

    acc_arbiter #(.NREQ(NREQ), .BURST_LEN(BURST_LEN), .IDW(IDW)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .DV(dv), .D(d),
        .GNT(gnt), .Q(q), .QV(qv), .QACK(qack), .QID(qid), .BUSY(busy)
`ifdef SAT_EN
        , .OVF(ovf)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ptr   = NREQ - 1;
    int exp_gnt[$];
    int exp_id[$];
    int exp_q[$];
    int exp_ovf[$];
    int dvals[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            int idx = (p + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset(input logic [NREQ-1:0] r);
        rst = 1'b1; req = r; dv = '0; qack = 1'b0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_q", 32'(q), 0);
        check("rst_qv", 32'(qv), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_qid", 32'(qid), 0);
`ifdef SAT_EN
        check("rst_ovf", 32'(ovf), 0);
`endif
        exp_gnt.delete(); exp_id.delete(); exp_q.delete(); exp_ovf.delete();
        dvals.delete();
        ptr = NREQ - 1;
        rst = 1'b0; req = '0;
        tick();
    endtask

    // One grant cycle: n accepted samples, then release (same cycle or one later)
    task automatic run_burst(input logic [NREQ-1:0] r, input int n, input bit drop_same,
                             input bit gaps, input bit noise_all, input int abort_at,
                             input bit ack_reset);
        int g, cnt, sum, ovfm, v, w;
        g = pick(r, ptr);
        ptr = g;
        exp_gnt.push_back(g);
        req = r; dv = '0; qack = 1'b0;
        tick();
        cnt = 0; sum = 0; ovfm = 0;
        if (n == 0) begin
            dv = NREQ'($urandom); dv[g] = 1'b0; req[g] = 1'b0;
            exp_id.push_back(g); exp_q.push_back(0); exp_ovf.push_back(0);
            tick();
        end else begin
            while (cnt < n) begin
                if (abort_at >= 0 && cnt == abort_at) begin
                    do_reset(r);
                    return;
                end
                for (int i = 0; i < NREQ; i++) d[16*i +: 16] = 16'($urandom);
                dv = noise_all ? '1 : NREQ'($urandom);
                qack = 1'($urandom);
                if (gaps && $urandom_range(0, 3) == 0) begin
                    dv[g] = 1'b0;
                end else begin
                    if (dvals.size() > 0) v = dvals.pop_front();
                    else                  v = int'($urandom_range(0, 65535));
                    d[16*g +: 16] = 16'(v);
                    dv[g] = 1'b1;
`ifdef SAT_EN
                    if (sum + v > 65535) begin sum = 65535; ovfm = 1; end
                    else sum = sum + v;
`else
                    sum = (sum + v) % 65536;
`endif
                    cnt++;
                    if (cnt == n) begin
                        if (n < BURST_LEN && drop_same) req[g] = 1'b0;
                        if (n == BURST_LEN || drop_same) begin
                            exp_id.push_back(g); exp_q.push_back(sum); exp_ovf.push_back(ovfm);
                        end
                    end
                end
                tick();
            end
            if (n < BURST_LEN && !drop_same) begin
                dv[g] = 1'b0; req[g] = 1'b0; qack = 1'b0;
                exp_id.push_back(g); exp_q.push_back(sum); exp_ovf.push_back(ovfm);
                tick();
            end
        end
        // New requests raised now must not be granted before the handshake completes
        dv = '0; qack = 1'b0; req = NREQ'($urandom);
        w = 0;
        while (!qv && w < 4) begin tick(); w++; end
        check("qv_latency", 32'(w), 0);
        if (ack_reset) begin
            do_reset('0);
            return;
        end
        repeat ($urandom_range(0, 2)) tick();
        qack = 1'b1;
        tick();
        qack = 1'b0; req = '0;
        check("qv_after_ack", 32'(qv), 0);
        check("busy_after_ack", 32'(busy), 0);
    endtask

    // Monitor: pops expectations on grant rise and on result-valid rise
    initial begin
        logic [NREQ-1:0] prev_gnt;
        logic            prev_qv;
        int              e;
        prev_gnt = '0; prev_qv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (gnt != '0 && prev_gnt == '0) begin
                    if (exp_gnt.size() == 0) begin
                        total++; bad++;
                        $display("FAIL grant_unexpected: got %0h expected none", gnt);
                    end else begin
                        e = exp_gnt.pop_front();
                        check("gnt", 32'(gnt), 32'(1) << e);
                        check("gnt_qid", 32'(qid), 32'(e));
                        check("gnt_busy", 32'(busy), 1);
                    end
                end
                if (qv && !prev_qv) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL result_unexpected: got q=%0h expected none", q);
                    end else begin
                        check("res_q", 32'(q), 32'(exp_q.pop_front()));
                        check("res_qid", 32'(qid), 32'(exp_id.pop_front()));
                        check("res_gnt_off", 32'(gnt), 0);
`ifdef SAT_EN
                        check("res_ovf", 32'(ovf), 32'(exp_ovf.pop_front()));
`else
                        void'(exp_ovf.pop_front());
`endif
                    end
                end
            end
            prev_gnt = gnt;
            prev_qv  = qv;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all requests asserted, then requester 0 wins first
        do_reset(4'b1111);
        run_burst(4'b1111, 3, 1'b1, 1'b0, 1'b0, -1, 1'b0);

        // Full burst of 1..8 on requester 2
        for (int i = 1; i <= 8; i++) dvals.push_back(i);
        run_burst(4'b0100, 8, 1'b0, 1'b0, 1'b0, -1, 1'b0);

        // Round robin 0,1,3,0 with every DV high
        do_reset('0);
        repeat (4) run_burst(4'b1011, BURST_LEN, 1'b0, 1'b0, 1'b1, -1, 1'b0);

        // Early release with sample in the drop cycle
        repeat (4) dvals.push_back(16'h0100);
        run_burst(4'b0010, 4, 1'b1, 1'b0, 1'b0, -1, 1'b0);

        // Wrap or saturate
        dvals.push_back(16'hFFF0); dvals.push_back(16'h0020);
        run_burst(4'b0001, 2, 1'b1, 1'b0, 1'b0, -1, 1'b0);

        // Zero-sample burst
        run_burst(4'b1000, 0, 1'b0, 1'b0, 1'b0, -1, 1'b0);

        // Reset mid-accumulate and mid-handshake
        run_burst(4'b0100, BURST_LEN, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        run_burst(4'b1111, 2, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        run_burst(4'b1111, 1, 1'b1, 1'b0, 1'b0, -1, 1'b0);

        // Randomised bursts
        for (int t = 0; t < 40; t++) begin
            run_burst(NREQ'($urandom_range(1, 15)), int'($urandom_range(0, BURST_LEN)),
                      1'($urandom), 1'b1, 1'($urandom), -1, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        check("gnt_queue_empty", 32'(exp_gnt.size()), 0);
        check("res_queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
